smart_toilet_inlet_seq: RTL and testbench

SMART_TOILET_INLET_SEQ -- requirements
Module: smart_toilet_inlet_seq

---
 rtl/smart_toilet_inlet_seq.sv | 178 +++++++++++++++++
 tb/tb_smart_toilet_inlet_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/smart_toilet_inlet_seq.sv
// smart_toilet_inlet_seq: doses three solutions through inlet valves in the order
// soln3, soln2, soln1, lets the serpentine/mixer path settle, then flags done.
// Optional feature: define INLET_SEQ_ABORT_EN to enable the abort input and the
// sticky aborted flag; without it abort is ignored and aborted is tied low.
module smart_toilet_inlet_seq #(
   parameter int STEP_DIV = 4,
   parameter int TW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [7:0]    vol1,
   input  logic [7:0]    vol2,
   input  logic [7:0]    vol3,
   input  logic [TW-1:0] transit,
   input  logic          abort,
   output logic [2:0]    valve_open,
   output logic [2:0]    pump_step,
   output logic          busy,
   output logic          done,
   output logic          aborted
);

   typedef enum logic [2:0] {IDLE, DOSE3, DOSE2, DOSE1, SETTLE, DONE} state_t;

   localparam logic [7:0] LP_DIV_MAX = 8'(STEP_DIV - 1);

   state_t        r_state;
   logic [7:0]    r_div;
   logic [7:0]    r_step;
   logic [TW-1:0] r_settle;
   logic [7:0]    r_vol1, r_vol2, r_vol3;
   logic [TW-1:0] r_transit;
   logic [2:0]    r_valve;
   logic [2:0]    r_pump;
   logic          r_busy;
   logic          r_done;

   state_t        w_state;
   logic [7:0]    w_div;
   logic [7:0]    w_step;
   logic [TW-1:0] w_settle;
   logic          w_accept;
   logic          w_abort_in;
   logic [7:0]    w_cur_vol;
   logic [2:0]    w_valve_nxt;

`ifdef INLET_SEQ_ABORT_EN
   logic r_aborted;
   assign w_abort_in = abort;
   assign aborted    = r_aborted;
`else
   logic w_unused_abort;
   assign w_unused_abort = abort;
   assign w_abort_in     = 1'b0;
   assign aborted        = 1'b0;
`endif

   // First phase with work to do after 'from': remaining nonzero doses in order, then settle, then done
   function automatic state_t f_next_phase(input state_t from, input logic [7:0] v3,
                                           input logic [7:0] v2, input logic [7:0] v1,
                                           input logic [TW-1:0] t);
      state_t nxt;
      if (from == IDLE && v3 != 8'd0)
         nxt = DOSE3;
      else if ((from == IDLE || from == DOSE3) && v2 != 8'd0)
         nxt = DOSE2;
      else if ((from == IDLE || from == DOSE3 || from == DOSE2) && v1 != 8'd0)
         nxt = DOSE1;
      else if (t != '0)
         nxt = SETTLE;
      else
         nxt = DONE;
      return nxt;
   endfunction

   assign w_cur_vol = (r_state == DOSE3) ? r_vol3 :
                      (r_state == DOSE2) ? r_vol2 : r_vol1;

   // Next state and counter values; abort in a run overrides everything
   always_comb begin
      w_state  = r_state;
      w_div    = r_div;
      w_step   = r_step;
      w_settle = r_settle;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !w_abort_in) begin
               w_accept = 1'b1;
               w_state  = f_next_phase(IDLE, vol3, vol2, vol1, transit);
               w_div    = 8'd0;
               w_step   = 8'd0;
               w_settle = '0;
            end
         end
         DOSE3, DOSE2, DOSE1: begin
            if (r_div == LP_DIV_MAX) begin
               w_div = 8'd0;
               if (r_step == w_cur_vol - 8'd1) begin
                  w_step  = 8'd0;
                  w_state = f_next_phase(r_state, r_vol3, r_vol2, r_vol1, r_transit);
               end else begin
                  w_step = r_step + 8'd1;
               end
            end else begin
               w_div = r_div + 8'd1;
            end
         end
         SETTLE: begin
            if (r_settle == r_transit - TW'(1)) begin
               w_settle = '0;
               w_state  = DONE;
            end else begin
               w_settle = r_settle + TW'(1);
            end
         end
         DONE:    w_state = IDLE;
         default: w_state = IDLE;
      endcase
      if (w_abort_in && r_state != IDLE) begin
         w_state  = IDLE;
         w_div    = 8'd0;
         w_step   = 8'd0;
         w_settle = '0;
      end
   end

   assign w_valve_nxt = {w_state == DOSE3, w_state == DOSE2, w_state == DOSE1};

   // State, counters, latched run parameters and outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_div     <= 8'd0;
         r_step    <= 8'd0;
         r_settle  <= '0;
         r_vol1    <= 8'd0;
         r_vol2    <= 8'd0;
         r_vol3    <= 8'd0;
         r_transit <= '0;
         r_valve   <= 3'b000;
         r_pump    <= 3'b000;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef INLET_SEQ_ABORT_EN
         r_aborted <= 1'b0;
`endif
      end else begin
         r_state  <= w_state;
         r_div    <= w_div;
         r_step   <= w_step;
         r_settle <= w_settle;
         if (w_accept) begin
            r_vol1    <= vol1;
            r_vol2    <= vol2;
            r_vol3    <= vol3;
            r_transit <= transit;
         end
         r_valve <= w_valve_nxt;
         r_pump  <= (w_div == LP_DIV_MAX) ? w_valve_nxt : 3'b000;
         r_busy  <= (w_state != IDLE);
         r_done  <= (w_state == DONE);
`ifdef INLET_SEQ_ABORT_EN
         if (w_abort_in && r_state != IDLE)
            r_aborted <= 1'b1;
         else if (w_accept)
            r_aborted <= 1'b0;
`endif
      end
   end

   assign valve_open = r_valve;
   assign pump_step  = r_pump;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_smart_toilet_inlet_seq.sv
// Directed bench for smart_toilet_inlet_seq (STEP_DIV=4, TW=16).
// Cycle c of a run is the clock period following edge c-1, with start sampled at edge 0.
module tb_smart_toilet_inlet_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  vol1, vol2, vol3;
   logic [15:0] transit;
   logic        abort;
   logic [2:0]  valve_open;
   logic [2:0]  pump_step;
   logic        busy, done, aborted;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] cap    [0:63];
   logic       cap_ab [0:63];

   smart_toilet_inlet_seq #(.STEP_DIV(4), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .vol1(vol1), .vol2(vol2), .vol3(vol3), .transit(transit), .abort(abort),
      .valve_open(valve_open), .pump_step(pump_step),
      .busy(busy), .done(done), .aborted(aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_vols(input logic [7:0] v1, input logic [7:0] v2,
                           input logic [7:0] v3, input logic [15:0] t);
      vol1 = v1; vol2 = v2; vol3 = v3; transit = t;
   endtask

   // Start a run at edge 0 and capture {valve,pump,busy,done} for cycles 1..n.
   // start is held for cycles s_lo..s_hi, abort for cycle ab_c; scr scrambles the
   // data inputs once the run has been accepted.
   task automatic run(input int n, input int s_lo, input int s_hi, input int ab_c, input bit scr);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scr) set_vols(8'hFF, 8'hFF, 8'hFF, 16'h0FFF);
      for (int c = 1; c <= n; c++) begin
         start     = (c >= s_lo && c <= s_hi);
         abort     = (c == ab_c);
         cap[c]    = {valve_open, pump_step, busy, done};
         cap_ab[c] = aborted;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Hand-derived profile for vol3=3, vol2=1, vol1=2, transit=5
   function automatic logic [7:0] f_main(input int c);
      logic [2:0] v;
      logic [2:0] p;
      v = 3'b000;
      p = 3'b000;
      if (c >= 1 && c <= 12)       v = 3'b100;
      else if (c >= 13 && c <= 16) v = 3'b010;
      else if (c >= 17 && c <= 24) v = 3'b001;
      if (c == 4 || c == 8 || c == 12) p = 3'b100;
      if (c == 16)                     p = 3'b010;
      if (c == 20 || c == 24)          p = 3'b001;
      return {v, p, (c >= 1 && c <= 30), (c == 30)};
   endfunction

   initial begin
      int nd;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      set_vols(8'd0, 8'd0, 8'd0, 16'd0);
      #12;
      chk("reset_outs", {valve_open, pump_step, busy, done, aborted}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Main sequence
      set_vols(8'd2, 8'd1, 8'd3, 16'd5);
      run(34, 0, 0, 0, 1'b1);
      nd = 0;
      for (int c = 1; c <= 34; c++) begin
         chk($sformatf("main_c%0d", c), cap[c], f_main(c));
         nd += int'(cap[c][0]);
      end
      chk("main_done_cnt", nd, 1);

      // All-zero run, then a new start on the cycle after DONE
      set_vols(8'd0, 8'd0, 8'd0, 16'd0);
      run(5, 2, 2, 0, 1'b0);
      chk("zero_c1", cap[1], 8'h03);
      chk("zero_c2", cap[2], 8'h00);
      chk("b2b_c3",  cap[3], 8'h03);
      chk("zero_c4", cap[4], 8'h00);
      chk("zero_c5", cap[5], 8'h00);

      // DOSE2 skipped: vol3=1, vol2=0, vol1=1, transit=0
      set_vols(8'd1, 8'd0, 8'd1, 16'd0);
      run(12, 0, 0, 0, 1'b1);
      chk("skip_valve_c4", cap[4][7:5], 3'b100);
      chk("skip_valve_c5", cap[5][7:5], 3'b001);
      chk("skip_pump_c4",  cap[4][4:2], 3'b100);
      chk("skip_pump_c8",  cap[8][4:2], 3'b001);
      chk("skip_done_c9",  cap[9][1:0], 2'b11);
      chk("skip_idle_c10", cap[10], 8'h00);

      // start held high during the run must change nothing
      set_vols(8'd2, 8'd1, 8'd3, 16'd5);
      run(34, 3, 30, 0, 1'b1);
      nd = 0;
      for (int c = 1; c <= 34; c++) begin
         chk($sformatf("restart_c%0d", c), cap[c], f_main(c));
         nd += int'(cap[c][0]);
      end
      chk("restart_done_cnt", nd, 1);

`ifdef INLET_SEQ_ABORT_EN
      // Abort in cycle 6 of the main sequence
      set_vols(8'd2, 8'd1, 8'd3, 16'd5);
      run(34, 0, 0, 6, 1'b1);
      for (int c = 1; c <= 34; c++) begin
         chk($sformatf("abort_c%0d", c), cap[c], (c <= 6) ? f_main(c) : 8'h00);
         chk($sformatf("abort_flag_c%0d", c), cap_ab[c], (c >= 7));
      end
      // abort and start together in IDLE: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("abort_wins_busy", busy, 1'b0);
      chk("abort_wins_flag", aborted, 1'b1);
      set_vols(8'd0, 8'd0, 8'd0, 16'd0);
      run(2, 0, 0, 0, 1'b0);
      chk("abort_clear_flag", cap_ab[1], 1'b0);
      chk("abort_clear_done", cap[1], 8'h03);
`else
      // abort is ignored in the default build
      set_vols(8'd2, 8'd1, 8'd3, 16'd5);
      run(34, 0, 0, 6, 1'b1);
      for (int c = 1; c <= 34; c++) begin
         chk($sformatf("noabort_c%0d", c), cap[c], f_main(c));
         chk($sformatf("noabort_flag_c%0d", c), cap_ab[c], 1'b0);
      end
`endif

      // Reset asserted mid-DOSE2: vol3=1, vol2=2, vol1=1, transit=3 (DOSE2 in cycles 5..12)
      set_vols(8'd1, 8'd2, 8'd1, 16'd3);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_pre_valve", valve_open, 3'b010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {valve_open, pump_step, busy, done, aborted}, 9'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_outs", {valve_open, pump_step, busy, done, aborted}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_after_c%0d", c), {valve_open, pump_step, busy, done}, 8'h00);
      end
      set_vols(8'd0, 8'd0, 8'd0, 16'd0);
      run(2, 0, 0, 0, 1'b0);
      chk("rst_idle_run_c1", cap[1], 8'h03);
      chk("rst_idle_run_c2", cap[2], 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
